// File: rtl/therm_accum_if.sv
// Handshake bundle for therm_accum: thermometer word stream in, frame totals out.
interface therm_accum_if #(
    parameter int W     = 3,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_therm;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic [CNT_W-1:0] out_words;
    logic             out_err;
    logic             out_ovf;

    modport master (
        output in_valid, in_therm, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_words, out_err, out_ovf
    );

    modport slave (
        input  in_valid, in_therm, in_last, out_ready,
        output in_ready, out_valid, out_count, out_words, out_err, out_ovf
    );
endinterface

// File: rtl/therm_accum.sv
// Sums ones-counts of sorted thermometer words over a frame and holds the
// saturated frame totals until the downstream handshake.
module therm_accum #(
    parameter int W     = 3,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    therm_accum_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_count_q, out_count_d;
    logic [CNT_W-1:0] out_words_q, out_words_d;
    logic             out_err_q, out_err_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W:0]   pop;
    logic [ACC_W:0]   sum;
    logic             illegal;
    logic             accept;
    logic             words_full;
    logic [ACC_W-1:0] acc_inc;
    logic [CNT_W-1:0] words_inc;
    logic             err_inc;
    logic             ovf_inc;

    // Datapath for the word being offered; only committed on acceptance.
    always_comb begin
        pop     = '0;
        illegal = 1'b0;
        for (int i = 0; i < W; i++) begin
            pop = pop + (ACC_W+1)'(bus.in_therm[i]);
        end
        for (int i = 1; i < W; i++) begin
            if (bus.in_therm[i] && !bus.in_therm[i-1]) illegal = 1'b1;
        end
        sum        = {1'b0, acc_q} + pop;
        acc_inc    = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
        words_full = (words_q == CNT_MAX);
        words_inc  = words_full ? words_q : words_q + CNT_W'(1);
        err_inc    = err_q | illegal;
        ovf_inc    = ovf_q | sum[ACC_W] | words_full;
        accept     = bus.in_valid && in_ready_q;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        words_d     = words_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        out_count_d = out_count_q;
        out_words_d = out_words_q;
        out_err_d   = out_err_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d   = acc_inc;
                    words_d = words_inc;
                    err_d   = err_inc;
                    ovf_d   = ovf_inc;
                    if (bus.in_last) begin
                        out_count_d = acc_inc;
                        out_words_d = words_inc;
                        out_err_d   = err_inc;
                        out_ovf_d   = ovf_inc;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        // Handshake flags follow the next state so they are pure registered state.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_count_q <= '0;
            out_words_q <= '0;
            out_err_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            words_q     <= words_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            out_count_q <= out_count_d;
            out_words_q <= out_words_d;
            out_err_q   <= out_err_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_words = out_words_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
